// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM, registered
// level plus press/release/long-press strobes and a short-press mode toggle.
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | button accepted as released, waiting for a high sample
// DEB_PRESS   | counting consecutive high samples before accepting press
// HELD        | press accepted, hold timer running toward long press
// DEB_RELEASE | counting consecutive low samples, hold timer still runs
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter int CNT_W           = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic mode_toggle
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic             sync1, sync2;
    logic [CNT_W-1:0] deb_cnt, deb_cnt_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic             long_fired, long_fired_nxt;
    logic             level_nxt, toggle_nxt;
    logic             press_nxt, release_nxt, long_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            state         <= IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            long_fired    <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            mode_toggle   <= 1'b0;
        end else begin
            sync1         <= btn_in;
            sync2         <= sync1;
            state         <= state_nxt;
            deb_cnt       <= deb_cnt_nxt;
            hold_cnt      <= hold_cnt_nxt;
            long_fired    <= long_fired_nxt;
            btn_level     <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_pulse    <= long_nxt;
            mode_toggle   <= toggle_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        deb_cnt_nxt    = deb_cnt;
        hold_cnt_nxt   = hold_cnt;
        long_fired_nxt = long_fired;
        level_nxt      = btn_level;
        toggle_nxt     = mode_toggle;
        press_nxt      = 1'b0;
        release_nxt    = 1'b0;
        long_nxt       = 1'b0;

        // Hold timer keeps running through a release bounce so a glitch
        // cannot postpone the long press.
        if (state == HELD || state == DEB_RELEASE) begin
            if (hold_cnt != HOLD_LAST) begin
                hold_cnt_nxt = hold_cnt + CNT_ONE;
            end else if (!long_fired) begin
                long_nxt       = 1'b1;
                long_fired_nxt = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (sync2) begin
                    state_nxt   = DEB_PRESS;
                    deb_cnt_nxt = CNT_ONE;
                end
            end
            DEB_PRESS: begin
                if (!sync2) begin
                    state_nxt = IDLE;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt      = HELD;
                    level_nxt      = 1'b1;
                    press_nxt      = 1'b1;
                    hold_cnt_nxt   = '0;
                    long_fired_nxt = 1'b0;
                end else begin
                    deb_cnt_nxt = deb_cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!sync2) begin
                    state_nxt   = DEB_RELEASE;
                    deb_cnt_nxt = CNT_ONE;
                end
            end
            DEB_RELEASE: begin
                if (sync2) begin
                    state_nxt = HELD;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt   = IDLE;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                    if (!long_fired) begin
                        toggle_nxt = ~mode_toggle;
                    end
                end else begin
                    deb_cnt_nxt = deb_cnt + CNT_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: run-length model of the debounced button checked
// every cycle, plus literal expectations at the key latency points.
module tb_btn_debounce;

    localparam int D = 4;
    localparam int L = 20;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic btn_level, press_pulse, release_pulse, long_pulse, mode_toggle;

    int checks   = 0;
    int failures = 0;

    btn_debounce #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .CNT_W          (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .mode_toggle  (mode_toggle)
    );

    initial forever #5 clk = ~clk;

    // Model: the filtered sample is btn_in from two edges earlier; an edge is
    // accepted once D consecutive samples disagree with the accepted level.
    bit hist0, hist1;
    int run, since;
    bit lvl, fired, m_tog, m_press, m_rel, m_long;

    task automatic model_step();
        bit s;
        bit old_fired;
        if (!rst) begin
            hist0 = 0; hist1 = 0; run = 0; since = 0;
            lvl = 0; fired = 0; m_tog = 0;
            m_press = 0; m_rel = 0; m_long = 0;
        end else begin
            s = hist1;
            hist1 = hist0;
            hist0 = btn_in;
            m_press = 0; m_rel = 0; m_long = 0;
            old_fired = fired;
            if (lvl) begin
                since++;
                if (since >= L && !fired) begin
                    m_long = 1;
                    fired  = 1;
                end
            end
            if (s != lvl) run++;
            else run = 0;
            if (run == D) begin
                run = 0;
                if (!lvl) begin
                    lvl = 1; m_press = 1; since = 0; fired = 0;
                end else begin
                    lvl = 0; m_rel = 1;
                    if (!old_fired) m_tog = ~m_tog;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        check("cyc.level",   btn_level,     lvl);
        check("cyc.press",   press_pulse,   m_press);
        check("cyc.release", release_pulse, m_rel);
        check("cyc.long",    long_pulse,    m_long);
        check("cyc.toggle",  mode_toggle,   m_tog);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Literal expectations applied to both the DUT and the model.
    task automatic expect_all(input string tag, input bit p, input bit r,
                              input bit lg, input bit lv, input bit tg);
        check({tag, ".press"},     press_pulse,   p);
        check({tag, ".release"},   release_pulse, r);
        check({tag, ".long"},      long_pulse,    lg);
        check({tag, ".level"},     btn_level,     lv);
        check({tag, ".toggle"},    mode_toggle,   tg);
        check({tag, ".m_press"},   m_press,       p);
        check({tag, ".m_release"}, m_rel,         r);
        check({tag, ".m_long"},    m_long,        lg);
        check({tag, ".m_level"},   lvl,           lv);
        check({tag, ".m_toggle"},  m_tog,         tg);
    endtask

    task automatic short_press(input string tag, input bit tog_before, input bit tog_after);
        btn_in = 1'b1;
        tick(5);
        expect_all({tag, ".pre_press"}, 0, 0, 0, 0, tog_before);
        tick(1);
        expect_all({tag, ".press"}, 1, 0, 0, 1, tog_before);
        tick(10);
        btn_in = 1'b0;
        tick(5);
        expect_all({tag, ".pre_rel"}, 0, 0, 0, 1, tog_before);
        tick(1);
        expect_all({tag, ".rel"}, 0, 1, 0, 0, tog_after);
        tick(4);
    endtask

    initial begin
        rst    = 1'b0;
        btn_in = 1'b0;
        tick(3);
        expect_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick(3);

        // Clean press held into a long press, then released.
        btn_in = 1'b1;
        tick(5);
        expect_all("clean.e4", 0, 0, 0, 0, 0);
        tick(1);
        expect_all("clean.e5", 1, 0, 0, 1, 0);
        tick(1);
        expect_all("clean.e6", 0, 0, 0, 1, 0);
        tick(18);
        expect_all("long.e24", 0, 0, 0, 1, 0);
        tick(1);
        expect_all("long.e25", 0, 0, 1, 1, 0);
        tick(1);
        expect_all("long.e26", 0, 0, 0, 1, 0);
        tick(5);
        btn_in = 1'b0;
        tick(5);
        expect_all("long_rel.r4", 0, 0, 0, 1, 0);
        tick(1);
        expect_all("long_rel.r5", 0, 1, 0, 0, 0);
        tick(4);

        // Bounces shorter than the debounce window.
        for (int i = 0; i < 5; i++) begin
            btn_in = 1'b1;
            tick(3);
            btn_in = 1'b0;
            tick(3);
        end
        tick(8);
        expect_all("bounce", 0, 0, 0, 0, 0);

        short_press("short1", 0, 1);
        short_press("short2", 1, 0);

        // Release glitch inside a hold must not disturb the long press.
        btn_in = 1'b1;
        tick(6);
        expect_all("glitch.press", 1, 0, 0, 1, 0);
        tick(5);
        btn_in = 1'b0;
        tick(2);
        btn_in = 1'b1;
        tick(12);
        expect_all("glitch.e24", 0, 0, 0, 1, 0);
        tick(1);
        expect_all("glitch.e25", 0, 0, 1, 1, 0);
        tick(2);
        btn_in = 1'b0;
        tick(6);
        expect_all("glitch.rel", 0, 1, 0, 0, 0);
        tick(4);

        // Reset while held, button still pressed afterwards.
        short_press("short3", 0, 1);
        btn_in = 1'b1;
        tick(8);
        expect_all("pre_rst", 0, 0, 0, 1, 1);
        rst = 1'b0;
        tick(1);
        expect_all("mid_rst", 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick(5);
        expect_all("post_rst.e5", 0, 0, 0, 0, 0);
        tick(1);
        expect_all("post_rst.e6", 1, 0, 0, 1, 0);
        tick(3);
        btn_in = 1'b0;
        tick(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Upstream conditioning stage for the board push-button that drives the LED blinker.
- Synchronises and debounces the raw button input.
- Produces a clean level, single-cycle press/release/long-press strobes, and a short-press toggle used as the blinker enable.
- All logic sits on the single system clock (50 MHz board clock).

Parameters:
- DEBOUNCE_CYCLES, 500_000, number of consecutive stable synchronised samples required to accept an edge (10 ms at 50 MHz); legal range is 2 or more.
- LONG_CYCLES, 50_000_000, number of cycles after an accepted press at which long_pulse fires (1 s); must be greater than DEBOUNCE_CYCLES.
- CNT_W, 26, width of both internal counters; must hold LONG_CYCLES-1.

Ports:
- clk  input  1  system clock; every register updates on its rising edge.
- rst  input  1  synchronous active-low reset; rst==0 sampled at a clk edge resets the block.
- btn_in  input  1  raw asynchronous button, active-high, bouncy.
- btn_level  output  1  debounced button level.
- press_pulse  output  1  one-cycle strobe on each accepted press.
- release_pulse  output  1  one-cycle strobe on each accepted release.
- long_pulse  output  1  one-cycle strobe when a press has been held LONG_CYCLES cycles.
- mode_toggle  output  1  flips on each accepted release that was not a long press.

Behaviour:
- All outputs are registered; there is no combinational path from btn_in to any output.
- Reset (rst==0 at an edge):
  - sync1, sync2, deb_cnt, hold_cnt and long_fired clear to 0.
  - state goes to IDLE.
  - btn_level, press_pulse, release_pulse, long_pulse and mode_toggle go to 0.
  - Reset takes priority over everything else, including mid-debounce and mid-hold; no strobe is emitted because of reset.
- Synchroniser: sync1<=btn_in, sync2<=sync1. The FSM uses only sync2.
- All three pulse outputs default to 0 every cycle and are high only in the cycle after the edge that sets them.
- IDLE:
  - sync2==1: go to DEB_PRESS, deb_cnt<=1.
  - Otherwise stay in IDLE.
- DEB_PRESS:
  - sync2==0: return to IDLE; no strobe.
  - sync2==1 and deb_cnt==DEBOUNCE_CYCLES-1: go to HELD, btn_level<=1, press_pulse<=1, hold_cnt<=0, long_fired<=0.
  - Otherwise deb_cnt<=deb_cnt+1.
- HELD:
  - hold_cnt increments every cycle and saturates at LONG_CYCLES-1.
  - hold_cnt==LONG_CYCLES-1 with long_fired==0: long_pulse<=1, long_fired<=1.
  - sync2==0: go to DEB_RELEASE, deb_cnt<=1.
- DEB_RELEASE:
  - hold_cnt keeps counting; the long_pulse rule from HELD still applies.
  - sync2==1: return to HELD; no strobe, no re-press.
  - sync2==0 and deb_cnt==DEBOUNCE_CYCLES-1: go to IDLE, btn_level<=0, release_pulse<=1; if long_fired==0 then mode_toggle<=~mode_toggle.
  - Otherwise deb_cnt<=deb_cnt+1.
- Latency:
  - Let E0 be the first edge that samples a new btn_in level, with that level held steady afterwards.
  - press_pulse (or release_pulse) is high in the cycle after edge E0+DEBOUNCE_CYCLES+1.
  - btn_level changes at that same edge.
  - long_pulse occurs exactly LONG_CYCLES edges after the press_pulse edge.
- Boundary cases:
  - Bounce shorter than DEBOUNCE_CYCLES produces no strobe.
  - At most one long_pulse per press.
  - A release glitch inside a hold does not reset hold_cnt.
  - If btn_in is high while rst deasserts, the press is debounced and reported normally.
- Counters never wrap: deb_cnt is bounded by the state transitions and hold_cnt saturates.

Test Plan:
- Clean press: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, btn_in rises before E0 and is held -> btn_level=1 and press_pulse=1 for exactly one cycle after E5; no other strobe.
- Bounce reject: btn_in high for 3 cycles then low, repeated 5 times -> no strobes, btn_level stays 0, state returns to IDLE.
- Short press and release: press, hold 10 cycles, release -> release_pulse is one cycle after the 5th edge from the first low sample; mode_toggle goes 0 to 1; a second identical press/release -> mode_toggle goes back to 0.
- Long press: hold 30 cycles -> long_pulse is one cycle, exactly 20 edges after the press_pulse edge; on release, release_pulse fires and mode_toggle is unchanged.
- Release glitch: during hold, btn_in low for 2 cycles -> no release_pulse, btn_level stays 1, long_pulse timing is unaffected.
- Reset mid-operation: assert rst=0 for one edge while in HELD -> the next cycle has all outputs 0 and state IDLE; with btn_in still high after reset, press_pulse recurs after DEBOUNCE_CYCLES+1 edges.
